// File: rtl/conv_out_streamer.sv
// conv_out_streamer: captures the parallel conv_layer result array on a rising
// edge of layer_done_in and streams it row-major, one pixel per valid/ready
// handshake. Each pixel carries end-of-row and end-of-frame markers.
module conv_out_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMGROW      = 28,
    parameter int IMGCOL      = 28,
    parameter int KERNEL_SIZE = 5,
    localparam int OROWS      = IMGROW - KERNEL_SIZE + 1,
    localparam int OCOLS      = IMGCOL - KERNEL_SIZE + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [OROWS-1:0][OCOLS-1:0][DATA_WIDTH-1:0] conv_out,
    input  logic                                   layer_done_in,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last_col,
    output logic                                   out_last_frame,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   overrun_err
);
    localparam int RW = (OROWS > 1) ? $clog2(OROWS) : 1;
    localparam int CW = (OCOLS > 1) ? $clog2(OCOLS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, state_nxt;
    logic [OROWS-1:0][OCOLS-1:0][DATA_WIDTH-1:0] snap;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic done_q, start, hs, at_last_col, at_last_pix, fin, load;

    // done_q resets high so a layer_done level held across reset is not an edge
    assign start       = layer_done_in & ~done_q;
    assign out_valid   = (state == STREAM);
    assign busy        = out_valid;
    assign hs          = out_valid & out_ready;
    assign at_last_col = (col == CW'(OCOLS - 1));
    assign at_last_pix = at_last_col && (row == RW'(OROWS - 1));
    assign fin         = hs & at_last_pix;
    // A new frame is accepted when idle, or on the very edge the old one completes
    assign load        = start & ((state == IDLE) | fin);

    // Outputs gated by out_valid so everything reads 0 outside a stream
    assign out_data       = out_valid ? snap[row][col] : '0;
    assign out_last_col   = out_valid & at_last_col;
    assign out_last_frame = out_valid & at_last_pix;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: stay in STREAM across a back-to-back frame boundary
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = STREAM;
            STREAM:  if (fin & ~start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge detector, completion pulse and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q      <= 1'b1;
            frame_done  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            done_q     <= layer_done_in;
            frame_done <= fin;
            if (start & (state == STREAM) & ~fin) overrun_err <= 1'b1;
        end
    end

    // Row/col pixel counters, row-major, advance on handshake
    always_ff @(posedge clk) begin
        if (rst || load || fin) begin
            row <= '0;
            col <= '0;
        end else if (hs) begin
            if (at_last_col) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Frame snapshot; pure datapath, outputs are gated so no reset needed
    always_ff @(posedge clk) begin
        if (!rst && load) snap <= conv_out;
    end
endmodule
